// File: rtl/dmem_arb_pkg.sv
// Shared types for the dm1 arbiter.
// Arbiter state, port owner and counter sizing.
package dmem_arb_pkg;

  typedef enum logic {
    NORMAL,
    LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_HOST
  } own_t;

  function automatic int wait_w(int m);
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Single-beat memory request port.
// master = requester, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata
  );

endinterface

// File: rtl/arb_wait_ctr.sv
// Saturating up-counter with clear.
// Holds at MAX; clear wins over increment.
module arb_wait_ctr #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dm1 between core LSU and host/DMA port.
// Core has priority; host gets bounded wait and burst lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 16
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   cpu,
  dmem_arbiter_if.slave   host,
  input  logic            host_lock,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            locked,
  output logic [CW-1:0]   stall_cnt
);

  localparam int WW = wait_w(MAX_WAIT);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  arb_state_t    state;
  own_t          own;
  logic [WW-1:0] wait_cnt;
  logic          wait_max;
  logic          stall_max;
  logic          host_wait;
  logic          host_clr;
  logic          cpu_stall;

  always_comb begin
    own = OWN_NONE;
    if (reset) begin
      own = OWN_NONE;
    end else if (state == LOCKED) begin
      own = host.req ? OWN_HOST : OWN_NONE;
    end else if (host.req && (!cpu.req || wait_max)) begin
      own = OWN_HOST;
    end else if (cpu.req) begin
      own = OWN_CPU;
    end
  end

  assign cpu.gnt    = (own == OWN_CPU);
  assign host.gnt   = (own == OWN_HOST);
  assign cpu.rdata  = mem_rdata;
  assign host.rdata = mem_rdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      own == OWN_CPU: begin
        mem_we    = cpu.we;
        mem_addr  = cpu.addr;
        mem_wdata = cpu.wdata;
      end
      own == OWN_HOST: begin
        mem_we    = host.we;
        mem_addr  = host.addr;
        mem_wdata = host.wdata;
      end
      default: ;
    endcase
  end

  // In LOCKED the host is granted whenever it asks,
  // so exit reduces to a dropped request or lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= NORMAL;
      locked <= 1'b0;
    end else begin
      unique case (state)
        NORMAL: begin
          if (host.gnt && host_lock) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (!host.req || !host_lock) begin
            state  <= NORMAL;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= NORMAL;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign host_wait = host.req & ~host.gnt;
  assign host_clr  = host.gnt | ~host.req;
  assign cpu_stall = cpu.req & ~cpu.gnt;

  arb_wait_ctr #(
    .W   (WW),
    .MAX (WMAX)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .inc    (host_wait),
    .clr    (host_clr),
    .cnt    (wait_cnt),
    .at_max (wait_max)
  );

  arb_wait_ctr #(
    .W   (CW),
    .MAX ({CW{1'b1}})
  ) u_stall (
    .clk    (clk),
    .reset  (reset),
    .inc    (cpu_stall),
    .clr    (1'b0),
    .cnt    (stall_cnt),
    .at_max (stall_max)
  );

  a_one_gnt: assert property (
    @(posedge clk) !(cpu.gnt && host.gnt));

  a_we_gnt: assert property (
    @(posedge clk) !mem_we || own != OWN_NONE);

  a_wait_rng: assert property (
    @(posedge clk) wait_cnt <= WMAX);

  a_stall_sat: assert property (
    @(posedge clk) disable iff (reset)
    stall_max |=> stall_max);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised + directed bench for dmem_arbiter.
// Behavioural model of grants, lock, wait and stall.
module tb_dmem_arbiter;

  localparam int MAXW = 4;
  localparam int CW   = 16;
  localparam int SMAX = (1 << CW) - 1;

  logic        clk;
  logic        reset;
  logic        host_lock;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        locked;
  logic [15:0] stall_cnt;

  dmem_arbiter_if #(.AW(8), .DW(8)) cpu_if ();
  dmem_arbiter_if #(.AW(8), .DW(8)) host_if ();

  dmem_arbiter #(
    .AW(8), .DW(8), .MAX_WAIT(MAXW), .CW(CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .host      (host_if),
    .host_lock (host_lock),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .locked    (locked),
    .stall_cnt (stall_cnt)
  );

  logic [7:0] core [256] = '{default: 8'h00};
  logic [7:0] mmem [256] = '{default: 8'h00};

  assign mem_rdata = core[mem_addr];

  always @(posedge clk)
    if (mem_we) core[mem_addr] <= mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;
  bit armed = 0;

  bit mlocked = 0;
  int mwait   = 0;
  int mstall  = 0;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL %s: got %0h expected %0h",
                 n, act, exp);
    end
  endtask

  // Model: owner chosen from the rule table, then
  // state advanced as it must be at the coming edge.
  always @(negedge clk) begin : cmp
    int         own_e;
    logic       ewe;
    logic [7:0] ea;
    logic [7:0] ed;
    if (armed) begin
      if (reset)
        own_e = 0;
      else if (mlocked)
        own_e = host_if.req ? 2 : 0;
      else if (cpu_if.req && host_if.req)
        own_e = (mwait >= MAXW) ? 2 : 1;
      else if (cpu_if.req)
        own_e = 1;
      else if (host_if.req)
        own_e = 2;
      else
        own_e = 0;
      ewe = 1'b0; ea = 8'h00; ed = 8'h00;
      if (own_e == 1) begin
        ewe = cpu_if.we; ea = cpu_if.addr;
        ed = cpu_if.wdata;
      end else if (own_e == 2) begin
        ewe = host_if.we; ea = host_if.addr;
        ed = host_if.wdata;
      end
      chk("cpu_gnt", 32'(cpu_if.gnt), 32'(own_e == 1));
      chk("host_gnt", 32'(host_if.gnt), 32'(own_e == 2));
      chk("both_gnt",
          32'(cpu_if.gnt & host_if.gnt), 0);
      chk("mem_we", 32'(mem_we), 32'(ewe));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_wdata", 32'(mem_wdata), 32'(ed));
      chk("locked", 32'(locked), 32'(mlocked));
      chk("stall_cnt", 32'(stall_cnt), mstall);
      if (own_e == 1 && !cpu_if.we)
        chk("cpu_rdata", 32'(cpu_if.rdata),
            32'(mmem[cpu_if.addr]));
      if (own_e == 2 && !host_if.we)
        chk("host_rdata", 32'(host_if.rdata),
            32'(mmem[host_if.addr]));
      if (reset) begin
        mlocked = 0; mwait = 0; mstall = 0;
      end else begin
        if (ewe) mmem[ea] = ed;
        if (cpu_if.req && own_e != 1 && mstall < SMAX)
          mstall++;
        if (own_e == 2 || !host_if.req)
          mwait = 0;
        else if (mwait < MAXW)
          mwait++;
        if (!mlocked)
          mlocked = (own_e == 2) && host_lock;
        else if (!host_if.req ||
                 (own_e == 2 && !host_lock))
          mlocked = 0;
      end
    end
  end

  task automatic drive(bit rst,
    bit cr, bit cw, logic [7:0] ca, logic [7:0] cd,
    bit hr, bit hl, bit hw, logic [7:0] ha,
    logic [7:0] hd);
    reset         = rst;
    cpu_if.req    = cr;
    cpu_if.we     = cw;
    cpu_if.addr   = ca;
    cpu_if.wdata  = cd;
    host_if.req   = hr;
    host_lock     = hl;
    host_if.we    = hw;
    host_if.addr  = ha;
    host_if.wdata = hd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic cpu_op(bit w, logic [7:0] a,
    logic [7:0] d, output logic [7:0] rd);
    bit done;
    done = 0;
    rd = 8'h00;
    for (int t = 0; t < 20 && !done; t++) begin
      drive(0, 1, w, a, d,
            1'($urandom_range(0, 1)), 0, 0, 8'd2,
            8'($urandom));
      #1;
      if (cpu_if.gnt) begin
        rd = cpu_if.rdata;
        done = 1;
      end
      step();
    end
    chk("cpu_op_timeout", 32'(done), 1);
  endtask

  initial begin : stim
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    int         bad;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    armed = 1;
    #1;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_gnt", 32'(cpu_if.gnt | host_if.gnt), 0);
    step();

    drive(0, 0, 0, 0, 0, 1, 0, 1, 8'd0, 8'hF0);
    #1; chk("pre_gnt0", 32'(host_if.gnt), 1); step();
    drive(0, 0, 0, 0, 0, 1, 0, 1, 8'd1, 8'hCC);
    #1; chk("pre_gnt1", 32'(host_if.gnt), 1); step();
    drive(0, 0, 0, 0, 0, 1, 0, 1, 8'd254, 8'h0F);
    #1; chk("pre_gnt2", 32'(host_if.gnt), 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_m0", 32'(core[0]), 32'hF0);
    chk("pre_m1", 32'(core[1]), 32'hCC);
    chk("pre_m254", 32'(core[254]), 32'h0F);
    step();

    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(0, 1, 0, 8'd0, 0, 1, 0, 0, 8'd1, 0);
      #1;
      chk("cont_cpu", 32'(cpu_if.gnt), 32'(k != 5));
      chk("cont_host", 32'(host_if.gnt), 32'(k == 5));
      if (k == 6)
        chk("cont_stall", 32'(stall_cnt), 1);
      step();
    end

    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 1, 8'd3, 8'hA3);
    step();
    chk("lk_locked", 32'(locked), 1);
    for (int k = 4; k <= 6; k++) begin
      drive(0, 1, 0, 8'd0, 0, 1, k != 6, 1,
            8'(k), 8'(8'hA0 + k));
      #1;
      chk("lk_cpu_stall", 32'(cpu_if.gnt), 0);
      chk("lk_host", 32'(host_if.gnt), 1);
      step();
    end
    drive(0, 1, 0, 8'd0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lk_cpu_back", 32'(cpu_if.gnt), 1);
    chk("lk_stall3", 32'(stall_cnt), 3);
    chk("lk_unlocked", 32'(locked), 0);
    chk("lk_m6", 32'(core[6]), 32'hA6);
    step();

    cpu_op(0, 8'd0, 0, a);
    cpu_op(0, 8'd1, 0, b);
    chk("xor_a", 32'(a), 32'hF0);
    chk("xor_b", 32'(b), 32'hCC);
    cpu_op(1, 8'd2, a ^ b, r);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("xor_m2", 32'(core[2]), 32'h3C);
    step();

    drive(0, 0, 0, 0, 0, 1, 1, 1, 8'd10, 8'h55);
    step();
    chk("rl_locked", 32'(locked), 1);
    drive(1, 1, 0, 8'd0, 0, 1, 1, 1, 8'd11, 8'h66);
    #1;
    chk("rl_host", 32'(host_if.gnt), 0);
    chk("rl_cpu", 32'(cpu_if.gnt), 0);
    chk("rl_we", 32'(mem_we), 0);
    step();
    chk("rl_m11", 32'(core[11]), 0);
    chk("rl_m10", 32'(core[10]), 32'h55);
    chk("rl_unlk", 32'(locked), 0);
    drive(0, 1, 0, 8'd0, 0, 1, 0, 0, 8'd11, 0);
    #1;
    chk("rl_cpu_win", 32'(cpu_if.gnt), 1);
    step();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 49) == 0,
        1'($urandom), 1'($urandom), 8'($urandom),
        8'($urandom),
        1'($urandom), $urandom_range(0, 2) == 0,
        1'($urandom), 8'($urandom), 8'($urandom));
      step();
    end

    do_reset();
    drive(0, 1, 0, 8'd0, 0, 1, 1, 0, 8'd1, 0);
    for (int i = 0; i < (1 << CW) + 6; i++)
      @(posedge clk);
    #1;
    chk("sat_stall", 32'(stall_cnt), 32'hFFFF);
    chk("sat_locked", 32'(locked), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (core[i] !== mmem[i]) bad++;
    chk("mem_image", bad, 0);

    armed = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             ncmp, nfail);
    $finish;
  end

endmodule
